// File: rtl/reduce_egress_pkg.sv
// Shared reduction-network definitions: flit field layout,
// egress route encodings and the per-dimension torus hop helper.
package reduce_egress_pkg;

  localparam int ValidBitPos = 81;
  localparam int DstXPos     = 72;
  localparam int DstYPos     = 75;
  localparam int DstZPos     = 78;
  localparam int CoordW      = 3;
  localparam int DirW        = 3;

  typedef enum logic [DirW-1:0] {
    DIR_LOCAL = 3'd0,
    DIR_XP    = 3'd1,
    DIR_XM    = 3'd2,
    DIR_YP    = 3'd3,
    DIR_YM    = 3'd4,
    DIR_ZP    = 3'd5,
    DIR_ZM    = 3'd6
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    HOP_NONE  = 2'd0,
    HOP_PLUS  = 2'd1,
    HOP_MINUS = 2'd2
  } hop_e;

  // Coordinate subtraction wraps natively at the ring size;
  // the halfway distance is sent the plus way.
  function automatic hop_e hop_dir(
    input logic [CoordW-1:0] dst,
    input logic [CoordW-1:0] rank,
    input logic [CoordW-1:0] half
  );
    logic [CoordW-1:0] d;
    hop_e              h;
    d = dst - rank;
    if (d == '0) begin
      h = HOP_NONE;
    end else if (d <= half) begin
      h = HOP_PLUS;
    end else begin
      h = HOP_MINUS;
    end
    return h;
  endfunction

endpackage

// File: rtl/reduce_egress_fifo.sv
// Egress flit buffer: circular storage with registered
// occupancy; full/empty derive from the count.
module egress_fifo #(
  parameter int Width = 82,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/reduce_egress.sv
// Reduction egress: buffers completed flits, routes them
// dimension-ordered over the torus and drives the output link.
module reduce_egress
  import reduce_egress_pkg::*;
#(
  parameter int          FlitWidth = 82,
  parameter int          FifoDepth = 4,
  parameter logic [2:0]  rank_x    = 3'b0,
  parameter logic [2:0]  rank_y    = 3'b0,
  parameter logic [2:0]  rank_z    = 3'b0,
  parameter int          DimSize   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done,
  input  logic [FlitWidth-1:0] Outpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [FlitWidth-1:0] out_flit,
  output logic [2:0]           out_dir,
  output logic                 buf_full,
  output logic                 drop_err,
  output logic [7:0]           drop_count
);

  localparam logic [CoordW-1:0] HalfDim = CoordW'(DimSize / 2);

  state_e               state_q, state_d;
  logic                 pop, push, push_req, drop;
  logic                 fifo_full, fifo_empty;
  logic [FlitWidth-1:0] head;
  dir_e                 route;
  logic [CoordW-1:0]    dx, dy, dz;
  hop_e                 hx, hy, hz;

  logic [FlitWidth-1:0] out_flit_q;
  logic [DirW-1:0]      out_dir_q;
  logic                 drop_err_q;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  // A pop frees a slot in the same cycle, so a full buffer
  // still takes a push while the head is leaving.
  assign push_req = done & Outpacket[ValidBitPos];
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  egress_fifo #(
    .Width (FlitWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (Outpacket),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          pop     = ~fifo_empty;
          state_d = fifo_empty ? ST_IDLE : ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dx    = head[DstXPos +: CoordW];
    dy    = head[DstYPos +: CoordW];
    dz    = head[DstZPos +: CoordW];
    hx    = hop_dir(dx, rank_x, HalfDim);
    hy    = hop_dir(dy, rank_y, HalfDim);
    hz    = hop_dir(dz, rank_z, HalfDim);
    route = DIR_LOCAL;
    if (hx != HOP_NONE) begin
      route = (hx == HOP_PLUS) ? DIR_XP : DIR_XM;
    end else if (hy != HOP_NONE) begin
      route = (hy == HOP_PLUS) ? DIR_YP : DIR_YM;
    end else if (hz != HOP_NONE) begin
      route = (hz == HOP_PLUS) ? DIR_ZP : DIR_ZM;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_flit_q <= '0;
      out_dir_q  <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_err_q <= drop;
      drop_cnt_q <= drop_cnt_d;
      if (pop) begin
        out_flit_q <= head;
        out_dir_q  <= route;
      end
    end
  end

  assign out_valid  = (state_q == ST_SEND);
  assign out_flit   = out_flit_q;
  assign out_dir    = out_dir_q;
  assign buf_full   = fifo_full;
  assign drop_err   = drop_err_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_reduce_egress.sv
// Bench for reduce_egress: two ranks driven in lockstep and
// compared against a queue-based model of the egress path.
module tb_reduce_egress;

  localparam int FW = 82;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          done = 1'b0;
  logic [FW-1:0] pkt = '0;
  logic          out_ready = 1'b0;

  logic          ov0, ov1, bf0, bf1, de0, de1;
  logic [FW-1:0] of0, of1;
  logic [2:0]    od0, od1;
  logic [7:0]    dc0, dc1;

  int errs = 0;
  int checks = 0;

  logic [FW-1:0] m_fifo[$];
  bit            m_ov = 0;
  logic [FW-1:0] m_flit = '0;
  bit            m_derr = 0;
  int            m_dcnt = 0;

  always #5 clk = ~clk;

  reduce_egress #(
    .rank_x(3'd0), .rank_y(3'd0), .rank_z(3'd0)
  ) dut0 (
    .clk(clk), .rst(rst), .done(done), .Outpacket(pkt),
    .out_ready(out_ready), .out_valid(ov0), .out_flit(of0),
    .out_dir(od0), .buf_full(bf0), .drop_err(de0),
    .drop_count(dc0)
  );

  reduce_egress #(
    .rank_x(3'd1), .rank_y(3'd2), .rank_z(3'd0)
  ) dut1 (
    .clk(clk), .rst(rst), .done(done), .Outpacket(pkt),
    .out_ready(out_ready), .out_valid(ov1), .out_flit(of1),
    .out_dir(od1), .buf_full(bf1), .drop_err(de1),
    .drop_count(dc1)
  );

  function automatic logic [2:0] exp_dir(
    input logic [FW-1:0] f, input int rx, input int ry,
    input int rz
  );
    int dst[3];
    int rk[3];
    dst[0] = int'(f[74:72]);
    dst[1] = int'(f[77:75]);
    dst[2] = int'(f[80:78]);
    rk[0] = rx; rk[1] = ry; rk[2] = rz;
    for (int k = 0; k < 3; k++) begin
      int d;
      d = (dst[k] - rk[k] + 8) % 8;
      if (d != 0) return (d <= 4) ? 3'(2*k+1) : 3'(2*k+2);
    end
    return 3'd0;
  endfunction

  function automatic logic [FW-1:0] mk(
    input bit v, input int x, input int y, input int z
  );
    logic [95:0]   r;
    logic [FW-1:0] p;
    r = {$urandom(), $urandom(), $urandom()};
    p = r[FW-1:0];
    p[81] = v;
    p[74:72] = 3'(x);
    p[77:75] = 3'(y);
    p[80:78] = 3'(z);
    return p;
  endfunction

  // One clock: drive inputs, advance the model, settle.
  task automatic step(
    input bit d, input logic [FW-1:0] p, input bit r
  );
    bit pop_m, acc;
    done = d; pkt = p; out_ready = r;
    @(posedge clk);
    if (rst) begin
      m_fifo.delete();
      m_ov = 0; m_flit = '0; m_derr = 0; m_dcnt = 0;
    end else begin
      pop_m = (!m_ov || r) && m_fifo.size() > 0;
      acc = d && p[81] && (m_fifo.size() < 4 || pop_m);
      m_derr = d && p[81] && !acc;
      if (m_derr && m_dcnt < 255) m_dcnt++;
      if (m_ov && r) m_ov = 0;
      if (pop_m) begin
        m_ov = 1;
        m_flit = m_fifo.pop_front();
      end
      if (acc) m_fifo.push_back(p);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, '0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1, mk(1, 3, 3, 3), 1);
    step(1, mk(1, 2, 1, 0), 0);
    rst = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
      errs++; $display("FAIL reset_valid: got %b%b want 00", ov0, ov1);
    end
    checks++;
    if (of0 !== '0 || od0 !== 3'd0) begin
      errs++; $display("FAIL reset_flit: got %0h/%0d want 0/0", of0, od0);
    end
    checks++;
    if (bf0 !== 1'b0 || de0 !== 1'b0 || dc0 !== 8'd0) begin
      errs++;
      $display("FAIL reset_status: got bf=%b de=%b dc=%0d want 0 0 0", bf0, de0, dc0);
    end
  endtask

  task automatic test_local();
    logic [FW-1:0] p;
    do_reset();
    p = mk(1, 0, 0, 0);
    step(1, p, 1);
    checks++;
    if (ov0 !== 1'b0) begin
      errs++; $display("FAIL local_latency: got %b want 0", ov0);
    end
    step(0, '0, 1);
    checks++;
    if (ov0 !== 1'b1 || of0 !== p) begin
      errs++; $display("FAIL local_flit: got %b/%0h want 1/%0h", ov0, of0, p);
    end
    checks++;
    if (od0 !== 3'd0) begin
      errs++; $display("FAIL local_dir: got %0d want 0", od0);
    end
    checks++;
    if (od1 !== exp_dir(p, 1, 2, 0)) begin
      errs++; $display("FAIL local_dir_r1: got %0d want %0d", od1, exp_dir(p, 1, 2, 0));
    end
    step(0, '0, 1);
  endtask

  task automatic test_wrap();
    int dst[3][3];
    int want1[3];
    logic [FW-1:0] p;
    dst[0] = '{6, 2, 0}; want1[0] = 2;
    dst[1] = '{5, 2, 0}; want1[1] = 1;
    dst[2] = '{1, 2, 3}; want1[2] = 5;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      p = mk(1, dst[i][0], dst[i][1], dst[i][2]);
      step(1, p, 1);
      step(0, '0, 1);
      checks++;
      if (ov1 !== 1'b1 || od1 !== 3'(want1[i])) begin
        errs++; $display("FAIL wrap_dir%0d: got %b/%0d want 1/%0d", i, ov1, od1, want1[i]);
      end
      checks++;
      if (od0 !== exp_dir(p, 0, 0, 0)) begin
        errs++; $display("FAIL wrap_dir_r0_%0d: got %0d want %0d", i, od0, exp_dir(p, 0, 0, 0));
      end
      step(0, '0, 1);
    end
  endtask

  task automatic drain_check(input logic [FW-1:0] exp[$], input string nm);
    logic [FW-1:0] got[$];
    for (int i = 0; i < 40 && got.size() < exp.size(); i++) begin
      if (ov0) got.push_back(of0);
      step(0, '0, 1);
    end
    checks++;
    if (got.size() != exp.size()) begin
      errs++; $display("FAIL %s_count: got %0d want %0d", nm, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errs++; $display("FAIL %s_order%0d: got %0h want %0h", nm, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] sent[$];
    logic [FW-1:0] p;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      p = mk(1, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      sent.push_back(p);
      step(1, p, 0);
    end
    checks++;
    if (ov0 !== 1'b1 || bf0 !== 1'b1 || dc0 !== 8'd0) begin
      errs++;
      $display("FAIL bp_full: got ov=%b bf=%b dc=%0d want 1 1 0", ov0, bf0, dc0);
    end
    step(1, mk(1, 1, 1, 1), 0);
    checks++;
    if (de0 !== 1'b1 || dc0 !== 8'd1) begin
      errs++; $display("FAIL bp_drop: got de=%b dc=%0d want 1 1", de0, dc0);
    end
    step(0, '0, 0);
    checks++;
    if (de0 !== 1'b0) begin
      errs++; $display("FAIL bp_pulse: got %b want 0", de0);
    end
    drain_check(sent, "bp");
  endtask

  task automatic test_full_pop();
    logic [FW-1:0] sent[$];
    logic [FW-1:0] p;
    for (int i = 0; i < 5; i++) begin
      p = mk(1, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      sent.push_back(p);
      step(1, p, 0);
    end
    p = mk(1, 4, 4, 4);
    sent.push_back(p);
    step(1, p, 1);
    checks++;
    if (de0 !== 1'b0 || dc0 !== 8'd1 || bf0 !== 1'b1) begin
      errs++;
      $display("FAIL fullpop: got de=%b dc=%0d bf=%b want 0 1 1", de0, dc0, bf0);
    end
    sent.pop_front();
    drain_check(sent, "fullpop");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, mk(1, 2, 2, 2), 0);
    rst = 1'b1;
    step(1, mk(1, 3, 0, 0), 0);
    rst = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || bf0 !== 1'b0) begin
      errs++; $display("FAIL rstmid: got ov=%b bf=%b want 0 0", ov0, bf0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1);
      checks++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
        errs++; $display("FAIL rstmid_stale%0d: got %b%b want 00", i, ov0, ov1);
      end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, mk(0, 0, 0, 0), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      checks++;
      if (ov0 !== 1'b0 || bf0 !== 1'b0) begin
        errs++; $display("FAIL invalid%0d: got ov=%b bf=%b want 0 0", i, ov0, bf0);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 270; i++) step(1, mk(1, 5, 5, 5), 0);
    checks++;
    if (dc0 !== 8'd255 || dc1 !== 8'd255 || de0 !== 1'b1) begin
      errs++; $display("FAIL sat: got dc=%0d/%0d de=%b want 255 1", dc0, dc1, de0);
    end
    do_reset();
    checks++;
    if (dc0 !== 8'd0) begin
      errs++; $display("FAIL sat_clear: got %0d want 0", dc0);
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] p;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = mk($urandom_range(9) < 8, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      step($urandom_range(9) < 6, p, $urandom_range(2) != 0);
      checks++;
      if (ov0 !== m_ov || ov1 !== m_ov) begin
        errs++; $display("FAIL rnd_valid@%0d: got %b%b want %b", i, ov0, ov1, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (of0 !== m_flit || of1 !== m_flit) begin
          errs++; $display("FAIL rnd_flit@%0d: got %0h want %0h", i, of0, m_flit);
        end
        checks++;
        if (od0 !== exp_dir(m_flit, 0, 0, 0) || od1 !== exp_dir(m_flit, 1, 2, 0)) begin
          errs++;
          $display("FAIL rnd_dir@%0d: got %0d/%0d want %0d/%0d", i, od0, od1,
                   exp_dir(m_flit, 0, 0, 0), exp_dir(m_flit, 1, 2, 0));
        end
      end
      checks++;
      if (bf0 !== (m_fifo.size() == 4) || de0 !== m_derr || dc0 !== 8'(m_dcnt)) begin
        errs++;
        $display("FAIL rnd_status@%0d: got bf=%b de=%b dc=%0d want %b %b %0d", i,
                 bf0, de0, dc0, m_fifo.size() == 4, m_derr, m_dcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_local();
    test_wrap();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_invalid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reduce_egress.md
REDUCE_EGRESS -- requirements
Module: reduce_egress

Interface
REQ-001 SHALL have parameter FlitWidth, default 82, flit width.
REQ-002 SHALL have parameter FifoDepth, default 4, egress buffer entries (power of two).
REQ-003 SHALL have parameters rank_x, rank_y, rank_z, default 3'b0, this node's torus coordinates.
REQ-004 SHALL have parameter DimSize, default 8, nodes per torus dimension (coordinates wrap modulo 8).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port done, input, 1, completed-reduction strobe from the reduction stage.
REQ-008 SHALL have port Outpacket, input, FlitWidth, completed reduction flit; sampled when done=1.
REQ-009 SHALL have port out_ready, input, 1, downstream link/host accepts the current flit.
REQ-010 SHALL have port out_valid, output, 1, out_flit/out_dir hold a flit.
REQ-011 SHALL have port out_flit, output, FlitWidth, flit forwarded unmodified.
REQ-012 SHALL have port out_dir, output, 3, route: 0 local host, 1 X+, 2 X-, 3 Y+, 4 Y-, 5 Z+, 6 Z-.
REQ-013 SHALL have port buf_full, output, 1, egress FIFO full.
REQ-014 SHALL have port drop_err, output, 1, one-cycle pulse on dropped flit.
REQ-015 SHALL have port drop_count, output, 8, saturating count of dropped flits.

Function
REQ-016 SHALL push Outpacket into the FIFO when done=1, valid bit (81) = 1 and the FIFO is not full; done with bit 81 = 0 is ignored.
REQ-017 SHALL, on done=1, bit 81 = 1 and a full FIFO with no pop that cycle, discard the flit, pulse drop_err and increment drop_count, saturating at 255.
REQ-018 SHALL accept the push when full if a pop occurs in the same cycle.
REQ-019 SHALL use a two-state output FSM: IDLE (out_valid=0) and SEND (out_valid=1).
REQ-020 SHALL, in IDLE with a non-empty FIFO, pop the head into the output register with its route and enter SEND.
REQ-021 SHALL, in SEND with out_ready=1, complete the transfer; if the FIFO is non-empty, load the next head the same cycle and stay in SEND, else return to IDLE.
REQ-022 SHALL hold out_flit and out_dir stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give latency one cycle: a flit pushed at edge N into an empty FIFO in IDLE is presented with out_valid=1 after edge N+1.
REQ-024 SHALL route dimension-ordered X, then Y, then Z, comparing dst fields (bits 74-72, 77-75, 80-78) with rank_x/y/z.
REQ-025 SHALL choose the direction in a dimension with d = (dst - rank) mod 8: + if 1<=d<=4, - if 5<=d<=7 (tie at d=4 goes +).
REQ-026 SHALL route a flit whose dst equals rank in all dimensions to out_dir=0.
REQ-027 SHALL support sustained throughput of one flit per cycle when out_ready is held at 1.
REQ-028 SHALL preserve FIFO order; the pointers wrap modulo FifoDepth.
REQ-029 SHALL compute buf_full from the registered occupancy count (0..FifoDepth).

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear FIFO pointers and count, enter IDLE, and drive out_valid=0, out_flit=0, out_dir=0, drop_err=0 and drop_count=0.
REQ-031 SHALL discard buffered and in-flight flits on a reset mid-operation; done asserted during reset is ignored.

Structure
REQ-032 SHALL take flit field positions (ValidBitPos, Dst_X/Y/ZPos, widths) and the out_dir encodings from the shared reduction-network package.
REQ-033 SHALL place the FIFO storage in one sub-module, egress_fifo; route computation is combinational logic in reduce_egress.

Verification
REQ-034 SHALL verify the local case: rank (0,0,0), push dst (0,0,0) with out_ready=1 -> out_valid the next cycle, out_dir=0, flit bit-identical.
REQ-035 SHALL verify torus wrap: rank_x=1, dst_x=6 (d=5) -> out_dir=2; dst_x=5 (d=4) -> out_dir=1; rank (1,2,0) to dst (1,2,3) -> out_dir=5.
REQ-036 SHALL verify backpressure: out_ready=0, push 5 flits -> 4 buffered plus 1 in output register, buf_full=1, drop_count=0; push a 6th -> drop_err pulse, drop_count=1; release out_ready -> 5 flits emerge in order.
REQ-037 SHALL verify full-with-pop: FIFO full, out_ready=1 and push in the same cycle -> push accepted, no drop.
REQ-038 SHALL verify reset mid-operation: rst asserted with 3 flits buffered -> next cycle out_valid=0, buf_full=0 and no stale flit appears after rst deasserts.
REQ-039 SHALL verify the invalid-bit case: done=1 with bit 81 = 0 -> no push and no output.
